// File: rtl/arith_shift_sequencer_if.sv
// Request/result handshake bundle for arith_shift_sequencer; master drives requests and result-accept.
interface arith_shift_sequencer_if #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] in_amount;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_amount, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amount, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/arith_shift_sequencer.sv
// Multi-cycle arithmetic right shift using one 0..3-place shifter; max(1,ceil(amt/3)) SHIFT cycles, then holds result until out_ready.
// One request in flight; in_ready only in IDLE. ARITH_SHIFT_ZERO_BYPASS_EN sends amount-0 requests straight to DONE.
module arith_shift_sequencer_asr #(
    parameter int N = 8
) (
    input  logic [N-1:0] d,
    input  logic [1:0]   sh,
    output logic [N-1:0] q
);
    assign q = $unsigned($signed(d) >>> sh);
endmodule

module arith_shift_sequencer #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    arith_shift_sequencer_if.slave  bus,
    output logic                    busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW:0]   AMT_LIM = (AW+1)'(N);
    localparam logic [AW-1:0] AMT_MAX = AW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  work_q, work_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [AW-1:0] amt_sat;
    logic [1:0]    step;
    logic [N-1:0]  shifted;

    // Non-power-of-two widths let in_amount exceed N-1; clamp at accept.
    always_comb begin
        amt_sat = bus.in_amount;
        if ({1'b0, bus.in_amount} >= AMT_LIM) begin
            amt_sat = AMT_MAX;
        end
    end

    always_comb begin
        step = rem_q[1:0];
        if (rem_q >= AW'(3)) begin
            step = 2'd3;
        end
    end

    arith_shift_sequencer_asr #(.N(N)) u_asr (
        .d  (work_q),
        .sh (step),
        .q  (shifted)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d = bus.in_data;
                    rem_d  = amt_sat;
`ifdef ARITH_SHIFT_ZERO_BYPASS_EN
                    state_d = (amt_sat == '0) ? DONE : SHIFT;
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - AW'(step);
                if (rem_q == AW'(step)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
        end
    end

    // work_q is frozen in DONE, so it doubles as the registered result.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = work_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Self-checking bench for arith_shift_sequencer: directed vector table, corner sequences, randomized model check.
module tb_arith_shift_sequencer;
    localparam int N  = 8;
    localparam int AW = 3;

`ifdef ARITH_SHIFT_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 1;
`endif

    logic clk;
    logic rst_n;
    logic busy;

    arith_shift_sequencer_if #(.N(N), .AW(AW)) bus ();

    arith_shift_sequencer #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (rst_n && bus.in_ready && bus.out_valid) overlap++;
    end

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            $display("FAIL wait_ready: in_ready still 0 after %0d cycles, expected 1", n);
        end
    endtask

    // Called just after the accept edge; returns at a negedge with out_ready low.
    task automatic wait_done(input bit rnd_rdy, output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        if (!bus.out_valid) begin
            checks++;
            $display("FAIL wait_done: out_valid still 0 after %0d cycles, expected 1", lat);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic [2:0] a);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amount = a;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'($urandom);
        bus.in_amount = 3'($urandom);
    endtask

    task automatic run_req(input string name, input logic [7:0] d, input logic [2:0] a,
                           input logic [7:0] exp, input int exp_lat, input int stall, input bit rnd);
        int lat;
        wait_ready();
        accept(d, a);
        wait_done(rnd, lat);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_data"}, 32'(bus.out_data), 32'(exp));
        if (stall > 0) begin
            repeat (stall) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
            end
            chk({name, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
            chk({name, "_hold_data"}, 32'(bus.out_data), 32'(exp));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        int lat;
        bit saw_vld;
        logic [7:0] rd;
        logic [2:0] ra;
        logic [7:0] rexp;
        int rlat;

        vt[0] = '{8'h80, 3'd7, 8'hFF, 3};
        vt[1] = '{8'hA5, 3'd2, 8'hE9, 1};
        vt[2] = '{8'h40, 3'd5, 8'h02, 2};
        vt[3] = '{8'h5A, 3'd0, 8'h5A, ZERO_LAT};
        vt[4] = '{8'h7F, 3'd7, 8'h00, 3};
        vt[5] = '{8'h81, 3'd3, 8'hF0, 1};
        vt[6] = '{8'h81, 3'd4, 8'hF8, 2};
        vt[7] = '{8'hC3, 3'd6, 8'hFF, 2};
        vt[8] = '{8'h33, 3'd1, 8'h19, 1};
        vt[9] = '{8'h80, 3'd0, 8'h80, ZERO_LAT};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amount = '0;
        bus.out_ready = 1'b0;
        #7;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_req($sformatf("vec%0d", i), vt[i].d, vt[i].a, vt[i].exp, vt[i].lat, 0, 1'b0);
        end

        // Stall in DONE for 5 cycles, with a competing request present at release.
        wait_ready();
        accept(8'hA5, 3'd2);
        wait_done(1'b0, lat);
        chk("stall_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_vld", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d_data", i), 32'(bus.out_data), 32'hE9);
            chk($sformatf("stall%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h40;
        bus.in_amount = 3'd5;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = 8'hFF;
        wait_done(1'b0, lat);
        chk("after_release_lat", 32'(lat), 32'd2);
        chk("after_release_data", 32'(bus.out_data), 32'h02);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset asserted during SHIFT aborts the request.
        wait_ready();
        accept(8'h80, 3'd7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out_data", 32'(bus.out_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_vld = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) saw_vld = 1'b1;
        end
        chk("abort_no_result", 32'(saw_vld), 32'd0);
        run_req("post_abort", 8'h80, 3'd1, 8'hC0, 1, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            rd   = 8'($urandom);
            ra   = 3'($urandom_range(0, N - 1));
            rexp = 8'($signed(rd) >>> ra);
            rlat = (ra == 0) ? ZERO_LAT : (int'(ra) + 2) / 3;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_req($sformatf("rnd%0d", i), rd, ra, rexp, rlat, $urandom_range(0, 3), 1'b1);
        end

        chk("ready_valid_exclusive", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end
endmodule

// File: doc/arith_shift_sequencer.md
ARITH_SHIFT_SEQUENCER -- requirements
Module: arith_shift_sequencer

Interface
REQ-001 Parameter N, default 8, data width in bits; legal range 4..32.
REQ-002 Parameter AW, default $clog2(N), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present on in_data/in_amount.
REQ-006 in_ready  output  1  sequencer can accept a request.
REQ-007 in_data  input  N  signed operand.
REQ-008 in_amount  input  AW  total arithmetic right-shift amount, 0..N-1.
REQ-009 out_valid  output  1  out_data holds a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  N  in_data arithmetically shifted right by in_amount.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL instantiate one arithmetic right shifter with a 2-bit control that shifts by 0..3 places, sign-filling from the MSB, and SHALL use it as its only shift datapath.
REQ-014 States: IDLE, SHIFT, DONE; encoding is an implementation choice.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, latch in_data into the work register and in_amount into the remaining counter, then go to SHIFT.
REQ-016 SHIFT: each cycle, step = min(remaining, 3); work <= shifter(work, step); remaining <= remaining - step; in_ready=0.
REQ-017 SHIFT -> DONE on the edge where remaining-step == 0; SHIFT SHALL last max(1, ceil(in_amount/3)) cycles.
REQ-018 DONE: out_valid=1 and out_data=work; hold out_valid and out_data stable until out_valid&out_ready; then go to IDLE.
REQ-019 out_data SHALL be registered; no combinational path from in_* to out_*.
REQ-020 Inputs sampled only on the accept edge; changes to in_data/in_amount afterwards SHALL NOT affect the result.
REQ-021 in_amount >= N (possible when N is not a power of 2) SHALL be saturated to N-1 at accept.
REQ-022 No new request accepted in DONE, even if out_ready is high in the same cycle; the next accept takes place at the earliest in the cycle after return to IDLE.
REQ-023 out_ready while not in DONE SHALL be ignored.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, work=0, remaining=0, out_valid=0, out_data=0, busy=0, in_ready=1 once released.
REQ-025 Reset asserted mid-operation SHALL abort the request; no out_valid is produced for it.
REQ-026 Release of rst_n SHALL occur synchronously to clk; the first accept is permitted on the first edge after release.

Configuration
REQ-027 Macro ARITH_SHIFT_ZERO_BYPASS_EN: when defined, an accepted request with in_amount==0 SHALL go IDLE -> DONE directly, with out_data=in_data and no SHIFT cycle.
REQ-028 Without ARITH_SHIFT_ZERO_BYPASS_EN, in_amount==0 SHALL spend exactly one SHIFT cycle with step 0 (REQ-017).

Verification
REQ-029 in_data=8'h80, in_amount=7, out_ready=1 -> steps 3,3,1; out_valid rises 3 cycles after accept with out_data=8'hFF.
REQ-030 in_data=8'hA5, in_amount=2 -> 1 SHIFT cycle; out_data=8'hE9; in_data=8'h40, in_amount=5 -> 2 SHIFT cycles; out_data=8'h02.
REQ-031 in_data=8'h5A, in_amount=0 -> out_data=8'h5A after 1 SHIFT cycle without macro, directly after accept with ARITH_SHIFT_ZERO_BYPASS_EN.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
REQ-033 Assert rst_n=0 during SHIFT of in_data=8'h80, in_amount=7 -> outputs at reset values immediately, no out_valid; a following request in_data=8'h80, in_amount=1 completes with out_data=8'hC0.
REQ-034 Randomised 200 requests with random out_ready stalls: every result equals a signed-shift reference model; in_ready and out_valid are never high together.
